weight_fetch_ctrl: RTL
======================

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 28, SHALL be the number of weight words fetched per run.
REQ-002 Parameter AW, default 5, SHALL be the BRAM address width.
REQ-003 Parameter DW, default 16, SHALL be the weight word width.
REQ-004 CLK  in  1  SHALL be the single clock; all logic is posedge, and there is one clock domain.
REQ-005 RST_N  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 START  in  1  SHALL be a run request, sampled at posedge.
REQ-007 BUSY  out  1  SHALL be high while a run is in progress.
REQ-008 DONE  out  1  SHALL be a one-cycle pulse at the end of a run.
REQ-009 BR_ADDR  out  AW  SHALL be the weight BRAM read address.
REQ-010 BR_EN  out  1  SHALL be the weight BRAM enable.
REQ-011 BR_WE  out  1  SHALL be the weight BRAM write enable, held constant 0.
REQ-012 BR_DI  out  DW  SHALL be the weight BRAM write data, held constant 0.
REQ-013 BR_DO  in  DW  SHALL be the weight BRAM read data; the BRAM updates it on negedge CLK.
REQ-014 W_DATA  out  DW  SHALL be the streamed weight word.
REQ-015 W_VALID  out  1  SHALL be high when W_DATA holds a valid word.
REQ-016 W_READY  in  1  SHALL be the consumer acceptance signal.
REQ-017 W_IDX  out  AW  SHALL be the address the current W_DATA word was read from.
REQ-018 W_LAST  out  1  SHALL be high with the word at index DEPTH-1.

Function
REQ-019 The FSM SHALL have exactly three states:
- IDLE -> FETCH on START.
- FETCH -> DRAIN when the read of address DEPTH-1 is issued.
- DRAIN -> IDLE when the word with W_LAST=1 is accepted.
REQ-020 BR_EN and BR_ADDR SHALL be registered outputs; a read issued at posedge E is presented during cycle E..E+1, and its BR_DO is captured at posedge E+1 (one-cycle read latency).
REQ-021 BR_EN SHALL be high only in cycles that carry an issued read; issued addresses SHALL be 0,1,...,DEPTH-1 in order, with none skipped or repeated.
REQ-022 Read data SHALL pass through a 2-entry FIFO whose head drives W_DATA, W_IDX and W_LAST; W_VALID SHALL equal "FIFO not empty".
REQ-023 Credit rule: a read SHALL be issued only when occupancy + in_flight - pop < 2, where pop = W_VALID & W_READY; the FIFO therefore never overflows.
REQ-024 With W_READY held at 1, one word per cycle SHALL be sustained with no bubbles.
REQ-025 W_DATA, W_IDX and W_LAST SHALL hold stable while W_VALID=1 and W_READY=0.
REQ-026 A handshake SHALL occur at a posedge with W_VALID=1 and W_READY=1; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-027 DONE SHALL pulse high for the cycle following acceptance of the W_LAST word; BUSY SHALL fall in that same cycle.
REQ-028 START SHALL be ignored while BUSY=1; START in the same cycle as DONE SHALL be ignored; START accepted from IDLE SHALL begin a new run at address 0.
REQ-029 The address counter SHALL be AW bits wide and SHALL never issue an address above DEPTH-1; it SHALL NOT wrap within a run.

Reset
REQ-030 While RST_N=0, the block SHALL force: BUSY=0, DONE=0, BR_EN=0, BR_ADDR=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0, FIFO empty, in_flight=0, state IDLE.
REQ-031 Reset asserted mid-run SHALL discard all buffered and in-flight data; no DONE pulse SHALL be produced.
REQ-032 After RST_N rises, the block SHALL idle until the next START.

Verification
REQ-033 BRAM model preloaded with mem[i]=16'h0100+i, W_READY=1, START sampled at E0 -> BR_EN high during E0..E28, W_VALID high during E1..E29, word k = 16'h0100+k accepted at E(2+k), W_LAST with k=27, DONE high during E29..E30.
REQ-034 W_READY=0 for 10 cycles after START -> at most 2 reads issued, W_DATA=16'h0100 held stable, no words lost or duplicated after release, all 28 delivered in order.
REQ-035 W_READY toggling every cycle -> 28 handshakes, W_IDX=0..27 in order, occupancy never above 2, BR_WE=0 throughout.
REQ-036 START pulsed at beat 10 of an active run -> no restart, addresses issued exactly once, exactly one DONE.
REQ-037 RST_N low at beat 15 -> all outputs 0 asynchronously, no DONE; a new START then delivers words 0..27 from address 0.
REQ-038 START in the same cycle as DONE -> ignored, BUSY stays 0.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - streams DEPTH weight words from a BRAM through a 2-entry credit-gated FIFO
module weight_fetch_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_br_addr,
  output logic          o_br_en,
  output logic          o_br_we,
  output logic [DW-1:0] o_br_di,
  input  logic [DW-1:0] i_br_do,
  output logic [DW-1:0] o_w_data,
  output logic          o_w_valid,
  input  logic          i_w_ready,
  output logic [AW-1:0] o_w_idx,
  output logic          o_w_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_br_en;
  logic [AW-1:0]   r_br_addr;
  logic            r_done;

  logic [DW-1:0]   r_fifo_data [2];
  logic [AW-1:0]   r_fifo_idx  [2];
  logic            r_fifo_last [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_head_last;
  logic [2:0]      w_pending;
  logic            w_credit_ok;
  logic            w_issue;
  logic [AW-1:0]   w_issue_addr;
  logic            w_done_nxt;

  // A read presented last cycle lands in the FIFO at this edge, so r_br_en is the in-flight count.
  assign w_push      = r_br_en;
  assign w_pop       = o_w_valid & i_w_ready;
  assign w_head_last = r_fifo_last[r_rd_ptr];
  assign w_pending   = {1'b0, r_count} + {2'b00, r_br_en};
  assign w_credit_ok = (w_pending - {2'b00, w_pop}) < 3'd2;

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_br_addr;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A START coinciding with the DONE pulse belongs to the finished run and is dropped.
        if (i_start && !r_done) begin
          w_issue      = 1'b1;
          w_issue_addr = '0;
          w_state_nxt  = (DEPTH == 1) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_credit_ok) begin
          w_issue      = 1'b1;
          w_issue_addr = r_br_addr + AW'(1);
          if (w_issue_addr == LAST_ADDR) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_br_en   <= 1'b0;
      r_br_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_br_en <= w_issue;
      r_done  <= w_done_nxt;
      if (w_issue) begin
        r_br_addr <= w_issue_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= i_br_do;
        r_fifo_idx[r_wr_ptr]  <= r_br_addr;
        r_fifo_last[r_wr_ptr] <= (r_br_addr == LAST_ADDR);
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_br_en   = r_br_en;
  assign o_br_addr = r_br_addr;
  assign o_br_we   = 1'b0;
  assign o_br_di   = '0;
  assign o_w_valid = (r_count != 2'd0);
  assign o_w_data  = r_fifo_data[r_rd_ptr];
  assign o_w_idx   = r_fifo_idx[r_rd_ptr];
  assign o_w_last  = r_fifo_last[r_rd_ptr];

endmodule
